decoder_3to8_pulse: RTL and testbench

Sequential 3-to-8 decoder. It accepts 3-bit binary codes through a valid/ready handshake and buffers them in a small FIFO. Each code is replayed as a one-hot pulse on an 8-bit output, held for a fixed number of cycles. It is the inverse of the 8-to-3 priority encoder: the encoder produces codes, and this block turns them back into one-hot strobes (e.g. channel select or interrupt acknowledge) with a guaranteed idle gap between consecutive strobes.

---
 rtl/decoder_3to8_pulse.sv | 124 ++++++++++++
 tb/tb_decoder_3to8_pulse.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_3to8_pulse.sv
// +--------------------------------------------------------------------------+
// | decoder_3to8_pulse : FIFO-buffered 3-to-8 decoder, one-hot timed pulses  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module decoder_3to8_pulse #(
  parameter int PULSE_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] Y,
  input  logic       valid,
  output logic       ready,
  output logic [7:0] D,
  output logic       busy,
  output logic       done
);

  localparam int             AW         = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [7:0]     CNT_LOAD   = 8'(PULSE_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  logic [1:0]    state_q, state_d;
  logic [7:0]    d_q, d_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [2:0]    w_head;

  assign ready   = (count_q < FULL_COUNT) && !rst;
  assign w_push  = valid && ready;
  assign w_empty = (count_q == '0);
  assign w_head  = mem_q[rd_ptr_q];
  // A pop happens only from IDLE or GAP, which enforces the one-cycle idle gap.
  assign w_pop   = !w_empty && ((state_q == S_IDLE) || (state_q == S_GAP));

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= Y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (w_pop) begin
          state_d = S_DRIVE;
          d_d     = 8'd1 << w_head;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = S_IDLE;
          d_d     = 8'h00;
        end
      end
      S_DRIVE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_GAP;
          d_d     = 8'h00;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        d_d     = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      d_q     <= 8'h00;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
    end
  end

  assign D    = d_q;
  assign busy = (state_q == S_DRIVE);
  assign done = (state_q == S_DRIVE) && (cnt_q == 8'd0);

endmodule

`default_nettype wire

// File: tb/tb_decoder_3to8_pulse.sv
// +--------------------------------------------------------------------------+
// | tb_decoder_3to8_pulse : scoreboard bench, two parameter sets             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_decoder_3to8_pulse;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int code;
    int start;
  } exp_t;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int PW = (gi == 0) ? 4 : 1;
    localparam int DP = (gi == 0) ? 4 : 2;

    logic       rst   = 1'b1;
    logic [2:0] Y     = 3'd0;
    logic       valid = 1'b0;
    logic       ready;
    logic [7:0] D;
    logic       busy;
    logic       done;
    bit         fin   = 1'b0;

    decoder_3to8_pulse #(.PULSE_W(PW), .DEPTH(DP)) dut (
      .clk   (clk),
      .rst   (rst),
      .Y     (Y),
      .valid (valid),
      .ready (ready),
      .D     (D),
      .busy  (busy),
      .done  (done)
    );

    // Reference: each accepted code starts one edge after acceptance, but no
    // earlier than PW+1 edges after the previous start.
    exp_t       q[$];
    int         prev_start = -1000;
    int         rst_edge   = -1;
    bit         armed      = 1'b0;
    logic [7:0] prev_d     = 8'h00;
    int         run        = 0;

    function automatic int model_count(input int e);
      int c = 0;
      foreach (q[k]) if (q[k].start > e) c++;
      return c;
    endfunction

    task automatic monitor_step();
      int   e;
      int   s;
      bit   exp_ready;
      exp_t h;
      e = edge_n;
      if (armed) begin
        if (e == rst_edge) begin
          check(D == 8'h00, "reset_D", int'(D), 0);
          check(!busy, "reset_busy", int'(busy), 0);
          check(!done, "reset_done", int'(done), 0);
        end
        check(busy == (D != 8'h00), "busy", int'(busy), int'(D != 8'h00));
        check($onehot0(D), "onehot", int'(D), 0);
        if (D != 8'h00 && prev_d == 8'h00) begin
          if (q.size() == 0) begin
            check(1'b0, "unexpected_pulse", int'(D), 0);
          end else begin
            h = q.pop_front();
            check(D == (8'd1 << h.code), "code", int'(D), 1 << h.code);
            check(e == h.start, "start_edge", e, h.start);
          end
          run = 1;
        end else if (D != 8'h00) begin
          check(D == prev_d, "hold", int'(D), int'(prev_d));
          run++;
        end else if (prev_d != 8'h00) begin
          if (e != rst_edge) check(run == PW, "pulse_len", run, PW);
          run = 0;
        end
        check(done == (D != 8'h00 && run == PW), "done", int'(done),
              int'(D != 8'h00 && run == PW));
        while (q.size() > 0 && q[0].start < e) begin
          check(1'b0, "missing_pulse", q[0].code, q[0].start);
          void'(q.pop_front());
        end
      end
      exp_ready = !rst && (model_count(e) < DP);
      if (armed) check(ready == exp_ready, "ready", int'(ready), int'(exp_ready));
      if (valid && exp_ready) begin
        s = (e + 2 > prev_start + PW + 1) ? e + 2 : prev_start + PW + 1;
        prev_start = s;
        q.push_back('{code: int'(Y), start: s});
      end
      if (rst) begin
        q.delete();
        prev_start = -1000;
        rst_edge   = e + 1;
        armed      = 1'b1;
      end
      prev_d = D;
    endtask

    initial begin
      forever begin
        @(negedge clk);
        monitor_step();
      end
    end

    task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
    endtask

    task automatic send(input int c);
      int k;
      k = 0;
      Y = 3'(c);
      valid = 1'b1;
      @(negedge clk);
      while (!ready && k < 400) begin
        @(negedge clk);
        k++;
      end
      if (k >= 400) check(1'b0, "handshake_timeout", k, 400);
      @(posedge clk);
      #1;
      valid = 1'b0;
    endtask

    task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
    endtask

    task automatic drain();
      int k;
      k = 0;
      while (q.size() > 0 && k < 500) begin
        @(posedge clk);
        k++;
      end
      #1;
      if (k >= 500) check(1'b0, "drain_timeout", q.size(), 0);
      idle(PW + 3);
    endtask

    initial begin
      int burst[5] = '{7, 0, 3, 3, 6};
      int fill[5]  = '{6, 1, 0, 7, 4};
      int r;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      if (gi == 0) begin
        send(5);
        idle(12);
        for (int c = 0; c < 8; c++) begin
          send(c);
          idle(9);
        end
        foreach (burst[k]) send(burst[k]);
        drain();
        foreach (fill[k]) send(fill[k]);
        Y = 3'd2;
        valid = 1'b1;
        idle(1);
        valid = 1'b0;
        drain();
        for (int c = 1; c <= 4; c++) send(c);
        pulse_rst();
        idle(15);
      end else begin
        send(1);
        send(4);
        drain();
      end
      for (int n = 0; n < 150; n++) begin
        r = $urandom_range(0, 19);
        if (r < 11) send($urandom_range(0, 7));
        else if (r == 19) pulse_rst();
        else idle($urandom_range(1, 4));
      end
      drain();
      fin = 1'b1;
    end
  end

  initial begin
    wait (g_cfg[0].fin && g_cfg[1].fin);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required completion before time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
